// File: rtl/dmul_complex_issuer.sv
// Initiator-side sequencer for a single double_multiplier: accepts one complex
// operand pair, issues the four real partial products in turn, presents them together.
module dmul_complex_issuer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_ar,
    input  logic [W-1:0] in_ai,
    input  logic [W-1:0] in_br,
    input  logic [W-1:0] in_bi,
    input  logic         in_stb,
    output logic         in_ack,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic         mul_a_stb,
    output logic         mul_b_stb,
    input  logic         mul_a_ack,
    input  logic         mul_b_ack,
    input  logic [W-1:0] mul_z,
    input  logic         mul_z_stb,
    output logic         mul_z_ack,
    output logic [W-1:0] p_rr,
    output logic [W-1:0] p_ii,
    output logic [W-1:0] p_ri,
    output logic [W-1:0] p_ir,
    output logic         out_stb,
    input  logic         out_ack
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, OUT} state_t;

    state_t         state;
    logic [1:0]     k;
    logic [W-1:0]   ar, ai, br, bi;
    logic           a_done, b_done;

    logic           a_fire, b_fire, both_done;
    logic [1:0]     k_next;
    logic [W-1:0]   next_a, next_b;

    always_comb begin
        a_fire    = mul_a_stb && mul_a_ack;
        b_fire    = mul_b_stb && mul_b_ack;
        both_done = (a_done || a_fire) && (b_done || b_fire);
        k_next    = k + 2'd1;
        // Product order rr, ii, ri, ir: a alternates ar/ai, b is bi for k = 1, 2.
        next_a    = k_next[0] ? ai : ar;
        next_b    = (k_next[0] ^ k_next[1]) ? bi : br;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            ar        <= '0;
            ai        <= '0;
            br        <= '0;
            bi        <= '0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            in_ack    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
            out_stb   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ack <= 1'b1;
                    if (in_stb && in_ack) begin
                        ar        <= in_ar;
                        ai        <= in_ai;
                        br        <= in_br;
                        bi        <= in_bi;
                        k         <= '0;
                        in_ack    <= 1'b0;
                        mul_a     <= in_ar;
                        mul_b     <= in_br;
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                        a_done    <= 1'b0;
                        b_done    <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (a_fire) begin
                        mul_a_stb <= 1'b0;
                        a_done    <= 1'b1;
                    end
                    if (b_fire) begin
                        mul_b_stb <= 1'b0;
                        b_done    <= 1'b1;
                    end
                    if (both_done) begin
                        mul_z_ack <= 1'b1;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (mul_z_stb && mul_z_ack) begin
                        mul_z_ack <= 1'b0;
                        case (k)
                            2'd0:    p_rr <= mul_z;
                            2'd1:    p_ii <= mul_z;
                            2'd2:    p_ri <= mul_z;
                            default: p_ir <= mul_z;
                        endcase
                        if (k == 2'd3) begin
                            out_stb <= 1'b1;
                            state   <= OUT;
                        end else begin
                            k         <= k_next;
                            mul_a     <= next_a;
                            mul_b     <= next_b;
                            mul_a_stb <= 1'b1;
                            mul_b_stb <= 1'b1;
                            a_done    <= 1'b0;
                            b_done    <= 1'b0;
                            state     <= SEND;
                        end
                    end
                end
                default: begin
                    if (out_ack) begin
                        out_stb <= 1'b0;
                        in_ack  <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmul_complex_issuer.sv
// Bench for dmul_complex_issuer: behavioural multiplier stub with configurable
// ack/result delays, expected operand pairs and products kept in scoreboard queues.
module tb_dmul_complex_issuer;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_ar = '0, in_ai = '0, in_br = '0, in_bi = '0;
    logic         in_stb = 1'b0;
    logic         in_ack;
    logic [W-1:0] mul_a, mul_b, mul_z;
    logic         mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack;
    logic         mul_z_stb, mul_z_ack;
    logic [W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic         out_stb;
    logic         out_ack = 1'b0;

    int passed = 0;
    int total  = 0;

    int           a_dly = 0, b_dly = 0, z_dly = 1;
    logic         fmode = 1'b0;
    logic         spur = 1'b0;
    logic [W-1:0] spur_val = '0;

    logic [2*W-1:0] exp_pairs[$];
    logic [4*W-1:0] exp_q[$];

    dmul_complex_issuer #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
        .in_stb(in_stb), .in_ack(in_ack),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
        .out_stb(out_stb), .out_ack(out_ack)
    );

    always #5 clk = ~clk;

    // Multiplier stub: acks each operand after its delay, returns z after z_dly cycles.
    logic [W-1:0] sa, sb, zr;
    logic         ga, gb, z_busy;
    int           a_cnt, b_cnt, z_cnt;

    assign mul_a_ack = mul_a_stb && (a_cnt >= a_dly);
    assign mul_b_ack = mul_b_stb && (b_cnt >= b_dly);
    assign mul_z_stb = (z_busy && z_cnt == 0) || spur;
    assign mul_z     = spur ? spur_val : zr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
            ga <= 1'b0; gb <= 1'b0; z_busy <= 1'b0;
            sa <= '0; sb <= '0; zr <= '0;
        end else begin
            a_cnt <= (mul_a_stb && !mul_a_ack) ? a_cnt + 1 : 0;
            b_cnt <= (mul_b_stb && !mul_b_ack) ? b_cnt + 1 : 0;
            if (mul_a_stb && mul_a_ack) begin sa <= mul_a; ga <= 1'b1; end
            if (mul_b_stb && mul_b_ack) begin sb <= mul_b; gb <= 1'b1; end
            if (ga && gb) begin
                total++;
                if (exp_pairs.size() == 0)
                    $display("FAIL pair_order: got %h,%h expected no request", sa, sb);
                else begin
                    logic [2*W-1:0] ep;
                    ep = exp_pairs.pop_front();
                    if ({sa, sb} !== ep)
                        $display("FAIL pair_order: got %h,%h expected %h,%h",
                                 sa, sb, ep[2*W-1:W], ep[W-1:0]);
                    else passed++;
                end
                zr <= fmode ? $realtobits($bitstoreal(sa) * $bitstoreal(sb)) : (sa ^ sb);
                z_busy <= 1'b1; z_cnt <= z_dly; ga <= 1'b0; gb <= 1'b0;
            end else if (z_busy) begin
                if (z_cnt != 0) z_cnt <= z_cnt - 1;
                else if (mul_z_ack) z_busy <= 1'b0;
            end
        end
    end

    // Product scoreboard: compared on the cycle the downstream transfer happens.
    always @(negedge clk) begin
        #1;
        if (!reset && out_stb && out_ack) begin
            logic [4*W-1:0] e, g;
            g = {p_rr, p_ii, p_ri, p_ir};
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL products: got %h expected no output", g);
            end else begin
                e = exp_q.pop_front();
                for (int j = 0; j < 4; j++) begin
                    total++;
                    if (g[4*W-1-W*j -: W] !== e[4*W-1-W*j -: W])
                        $display("FAIL product_%0d: got %h expected %h", j,
                                 g[4*W-1-W*j -: W], e[4*W-1-W*j -: W]);
                    else passed++;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] ar, ai, br, bi);
        int i;
        exp_pairs.push_back({ar, br});
        exp_pairs.push_back({ai, bi});
        exp_pairs.push_back({ar, bi});
        exp_pairs.push_back({ai, br});
        if (!fmode) exp_q.push_back({ar ^ br, ai ^ bi, ar ^ bi, ai ^ br});
        in_ar = ar; in_ai = ai; in_br = br; in_bi = bi; in_stb = 1'b1;
        i = 0;
        while (!in_ack && i < 50) begin @(negedge clk); i++; end
        total++;
        if (!in_ack) $display("FAIL in_ack_timeout: got 0 expected 1");
        else passed++;
        @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_out();
        int i;
        i = 0;
        while (!out_stb && i < 300) begin @(negedge clk); i++; end
        total++;
        if (!out_stb) $display("FAIL out_stb_timeout: got 0 expected 1");
        else passed++;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_stb} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_stb});
        else passed++;
        total++;
        if ({mul_a, mul_b, p_rr, p_ii, p_ri, p_ir} !== '0)
            $display("FAIL reset_data: got nonzero %h expected 0", p_rr | p_ii | mul_a);
        else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ack !== 1'b1) $display("FAIL reset_in_ack: got %b expected 1", in_ack);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ordering();
        issue(64'd1, 64'd2, 64'd4, 64'd8);
        wait_out();
    endtask

    task automatic test_split_ack();
        a_dly = 4; b_dly = 1;
        issue(64'd1, 64'd2, 64'd4, 64'd8);
        total++;
        if (!(mul_b_stb && mul_a_stb && mul_b == 64'd4))
            $display("FAIL split_start: got b_stb=%b b=%h expected 1 and 4", mul_b_stb, mul_b);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (!(mul_b_stb === 1'b0 && mul_a_stb === 1'b1 && mul_b === 64'd4))
            $display("FAIL split_b_early: got a_stb=%b b_stb=%b b=%h expected 1 0 4",
                     mul_a_stb, mul_b_stb, mul_b);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (mul_z_ack !== 1'b0 || mul_a_stb !== 1'b1)
                $display("FAIL split_no_wait_z: got z_ack=%b a_stb=%b expected 0 1",
                         mul_z_ack, mul_a_stb);
            else passed++;
        end
        wait_out();
        a_dly = 0; b_dly = 0;
    endtask

    task automatic test_spurious_z();
        a_dly = 3; b_dly = 3;
        issue(64'h11, 64'h22, 64'h44, 64'h88);
        spur = 1'b1; spur_val = 64'hDEAD_BEEF;
        @(negedge clk);
        spur = 1'b0;
        total++;
        if (mul_z_ack !== 1'b0 || mul_a_stb !== 1'b1 || mul_b_stb !== 1'b1)
            $display("FAIL spurious_state: got z_ack=%b a=%b b=%b expected 0 1 1",
                     mul_z_ack, mul_a_stb, mul_b_stb);
        else passed++;
        wait_out();
        a_dly = 0; b_dly = 0;
    endtask

    task automatic test_integration();
        fmode = 1'b1;
        exp_q.push_back({64'h3FB999999999999A, 64'h402A000000000000,
                         64'h4014CCCCCCCCCCCD, 64'h3FD0000000000000});
        issue(64'h3FF0000000000000, 64'h4004000000000000,
              64'h3FB999999999999A, 64'h4014CCCCCCCCCCCD);
        wait_out();
        fmode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [4*W-1:0] held;
        int i;
        issue(64'h5, 64'h6, 64'h30, 64'h41);
        i = 0;
        while (!out_stb && i < 300) begin @(negedge clk); i++; end
        held = {p_rr, p_ii, p_ri, p_ir};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_stb = (c == 3);
            in_ar = 64'h7;
            total++;
            if (out_stb !== 1'b1 || in_ack !== 1'b0 || {p_rr, p_ii, p_ri, p_ir} !== held)
                $display("FAIL backpressure_hold: got out_stb=%b in_ack=%b p_rr=%h expected 1 0 %h",
                         out_stb, in_ack, p_rr, held[4*W-1 -: W]);
            else passed++;
        end
        in_stb = 1'b0;
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        total++;
        if (out_stb !== 1'b0 || in_ack !== 1'b1)
            $display("FAIL backpressure_release: got out_stb=%b in_ack=%b expected 0 1",
                     out_stb, in_ack);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (mul_a_stb !== 1'b0 || exp_pairs.size() != 0)
            $display("FAIL busy_in_stb_ignored: got a_stb=%b pending=%0d expected 0 0",
                     mul_a_stb, exp_pairs.size());
        else passed++;
    endtask

    task automatic test_reset_midop();
        int i;
        z_dly = 6;
        issue(64'h3, 64'h5, 64'h9, 64'h11);
        i = 0;
        while (!(exp_pairs.size() == 1 && mul_z_ack) && i < 300) begin @(negedge clk); i++; end
        reset = 1'b1;
        #1;
        total++;
        if ({in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_stb} !== 5'b0 ||
            {p_rr, p_ii, p_ri, p_ir} !== '0)
            $display("FAIL reset_midop: got ctrl=%b p_rr=%h expected 00000 0",
                     {in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_stb}, p_rr);
        else passed++;
        exp_pairs.delete();
        exp_q.delete();
        z_dly = 1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ack !== 1'b1) $display("FAIL reset_midop_in_ack: got %b expected 1", in_ack);
        else passed++;
        @(negedge clk);
        issue(64'hA, 64'hB, 64'hC0, 64'hD00);
        wait_out();
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_split_ack();
        test_spurious_z();
        test_integration();
        test_backpressure();
        test_reset_midop();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0 || exp_pairs.size() != 0)
            $display("FAIL scoreboard_drained: got %0d/%0d pending expected 0/0",
                     exp_q.size(), exp_pairs.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
